// File: rtl/ex_issue_stage_pkg.sv
// Shared types and constants for the ID->EX issue register: FSM states,
// operand-select / branch-op codes and the registered EX bundle layout.
package ex_issue_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  localparam logic            B_SEL_RD2  = 1'b0;
  localparam logic            B_SEL_EXT  = 1'b1;
  localparam logic [2:0]      BR_OP_NONE = 3'b000;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [XLEN-1:0]   XLEN_ZERO = {XLEN{1'b0}};

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    logic              b_sel;
    logic [2:0]        br_op;
    logic [REG_AW-1:0] rd;
    logic              rf_we;
    logic              is_load;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   sext;
  } issue_t;

  // A bubble clears control and data alike so EX never sees stale operands.
  localparam issue_t ISSUE_BUBBLE = '0;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } fwd_src_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ID->EX issue bus: decoded ID fields and forwarding sources in,
// stall request and registered EX bundle out.
interface ex_issue_stage_if;
  import ex_issue_stage_pkg::*;

  logic              id_valid;
  logic [3:0]        id_alu_op;
  logic              id_b_sel;
  logic [2:0]        id_br_op;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rf_we;
  logic              id_is_load;
  logic [XLEN-1:0]   id_rD1;
  logic [XLEN-1:0]   id_rD2;
  logic [XLEN-1:0]   id_sext;
  logic              ex_f;
  logic [XLEN-1:0]   ex_C;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_we;
  logic [XLEN-1:0]   mem_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_we;
  logic [XLEN-1:0]   wb_data;

  logic              stall_id;
  logic              ex_valid;
  logic [3:0]        ex_alu_op;
  logic              ex_b_sel;
  logic [2:0]        ex_br_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rf_we;
  logic              ex_is_load;
  logic [XLEN-1:0]   ex_A;
  logic [XLEN-1:0]   ex_rD2;
  logic [XLEN-1:0]   ex_sext;

  modport master (
    output id_valid, id_alu_op, id_b_sel, id_br_op, id_rs1, id_rs2, id_rd,
           id_rf_we, id_is_load, id_rD1, id_rD2, id_sext, ex_f, ex_C,
           mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data,
    input  stall_id, ex_valid, ex_alu_op, ex_b_sel, ex_br_op, ex_rd,
           ex_rf_we, ex_is_load, ex_A, ex_rD2, ex_sext
  );

  modport slave (
    input  id_valid, id_alu_op, id_b_sel, id_br_op, id_rs1, id_rs2, id_rd,
           id_rf_we, id_is_load, id_rD1, id_rD2, id_sext, ex_f, ex_C,
           mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data,
    output stall_id, ex_valid, ex_alu_op, ex_b_sel, ex_br_op, ex_rd,
           ex_rf_we, ex_is_load, ex_A, ex_rD2, ex_sext
  );
endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// Per-operand RAW forwarding select: x0 reads zero, otherwise the youngest
// matching producer (ex > mem > wb) wins over the register-file value.
module ex_issue_stage_fwd_mux
  import ex_issue_stage_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_val,
  input  fwd_src_t          ex_src,
  input  fwd_src_t          mem_src,
  input  fwd_src_t          wb_src,
  output logic [XLEN-1:0]   val
);

  // Priority select of the forwarded operand value.
  always_comb begin
    val = rf_val;
    if (rs == REG_ZERO) begin
      val = XLEN_ZERO;
    end else if (ex_src.en && (ex_src.rd == rs)) begin
      val = ex_src.data;
    end else if (mem_src.en && (mem_src.rd == rs)) begin
      val = mem_src.data;
    end else if (wb_src.en && (wb_src.rd == rs)) begin
      val = wb_src.data;
    end else begin
      val = rf_val;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX issue register with issue-time forwarding, one-bubble load-use
// stall (RUN/BUBBLE FSM) and branch-flush squash.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ex_issue_stage_if.slave bus
);

  state_e          state_q, state_d;
  issue_t          ex_q, ex_d;
  issue_t          issue_word;
  logic            stall;
  logic            rs2_used;
  logic            hazard;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  fwd_src_t        ex_src, mem_src, wb_src;

  // A load in EX has no result yet, so it is never a forwarding source.
  assign ex_src  = '{en: ex_q.valid && ex_q.rf_we && !ex_q.is_load, rd: ex_q.rd, data: bus.ex_C};
  assign mem_src = '{en: bus.mem_we, rd: bus.mem_rd, data: bus.mem_data};
  assign wb_src  = '{en: bus.wb_we,  rd: bus.wb_rd,  data: bus.wb_data};

  ex_issue_stage_fwd_mux u_fwd_a (
    .rs(bus.id_rs1), .rf_val(bus.id_rD1),
    .ex_src(ex_src), .mem_src(mem_src), .wb_src(wb_src), .val(fwd_a)
  );

  ex_issue_stage_fwd_mux u_fwd_b (
    .rs(bus.id_rs2), .rf_val(bus.id_rD2),
    .ex_src(ex_src), .mem_src(mem_src), .wb_src(wb_src), .val(fwd_b)
  );

  // Load-use detection; any nonzero rs2 counts as used (superset of the exact rule).
  always_comb begin
    rs2_used = (bus.id_b_sel == B_SEL_RD2) || (bus.id_br_op != BR_OP_NONE) ||
               (bus.id_rs2 != REG_ZERO);
    hazard   = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.rf_we &&
               (ex_q.rd != REG_ZERO) &&
               ((ex_q.rd == bus.id_rs1) || ((ex_q.rd == bus.id_rs2) && rs2_used));
  end

  // Candidate EX bundle for the instruction currently in ID.
  always_comb begin
    issue_word = ISSUE_BUBBLE;
    if (bus.id_valid) begin
      issue_word.valid   = 1'b1;
      issue_word.alu_op  = bus.id_alu_op;
      issue_word.b_sel   = bus.id_b_sel;
      issue_word.br_op   = bus.id_br_op;
      issue_word.rd      = bus.id_rd;
      issue_word.rf_we   = bus.id_rf_we;
      issue_word.is_load = bus.id_is_load;
      issue_word.a       = fwd_a;
      issue_word.rd2     = fwd_b;
      issue_word.sext    = bus.id_sext;
    end else begin
      issue_word = ISSUE_BUBBLE;
    end
  end

  // Next-state / next-bundle: reset > flush > load-use stall > issue.
  always_comb begin
    state_d = state_q;
    ex_d    = ISSUE_BUBBLE;
    stall   = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (bus.ex_f) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            stall   = 1'b1;
            state_d = ST_BUBBLE;
          end else begin
            ex_d    = issue_word;
          end
        end
        ST_BUBBLE: begin
          // The load has moved to MEM; mem forwarding now supplies its data.
          ex_d    = issue_word;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and EX bundle registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= ISSUE_BUBBLE;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  assign bus.stall_id   = stall;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_alu_op  = ex_q.alu_op;
  assign bus.ex_b_sel   = ex_q.b_sel;
  assign bus.ex_br_op   = ex_q.br_op;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_rf_we   = ex_q.rf_we;
  assign bus.ex_is_load = ex_q.is_load;
  assign bus.ex_A       = ex_q.a;
  assign bus.ex_rD2     = ex_q.rd2;
  assign bus.ex_sext    = ex_q.sext;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios plus random traffic, all
// checked every cycle against a behavioural pipeline model.
module tb_ex_issue_stage;
  import ex_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_issue_stage_if bus();
  ex_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic v; logic [3:0] alu; logic bsel; logic [2:0] br; logic [4:0] rd;
    logic we; logic ld; logic [31:0] a; logic [31:0] d2; logic [31:0] sx;
  } mex_t;

  mex_t m_ex = '0;
  mex_t m_nxt;
  bit   m_known = 1'b0;
  bit   m_stalled = 1'b0;
  bit   m_stalled_nxt;
  logic obs_stall;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Youngest in-flight writer of rs supplies the value; x0 is always zero.
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (m_ex.v && m_ex.we && !m_ex.ld && m_ex.rd == rs) return bus.ex_C;
    if (bus.mem_we && bus.mem_rd == rs) return bus.mem_data;
    if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  task automatic model_eval(output logic exp_stall);
    bit load_use;
    load_use = bus.id_valid && m_ex.v && m_ex.ld && m_ex.we && m_ex.rd != 5'd0 &&
               (m_ex.rd == bus.id_rs1 || (m_ex.rd == bus.id_rs2 && bus.id_rs2 != 5'd0));
    exp_stall = 1'b0;
    m_nxt = '0;
    m_stalled_nxt = 1'b0;
    if (rst || bus.ex_f) begin
      m_nxt = '0;
    end else if (load_use && !m_stalled) begin
      exp_stall = 1'b1;
      m_stalled_nxt = 1'b1;
    end else if (bus.id_valid) begin
      m_nxt = '{1'b1, bus.id_alu_op, bus.id_b_sel, bus.id_br_op, bus.id_rd, bus.id_rf_we,
                bus.id_is_load, m_fwd(bus.id_rs1, bus.id_rD1), m_fwd(bus.id_rs2, bus.id_rD2),
                bus.id_sext};
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance both.
  task automatic cycle();
    logic exp_stall;
    #1;
    model_eval(exp_stall);
    obs_stall = bus.stall_id;
    chk("stall_id", {31'd0, obs_stall}, {31'd0, exp_stall});
    if (m_known) begin
      chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_ex.v});
      chk("ex_ctrl", {17'd0, bus.ex_alu_op, bus.ex_b_sel, bus.ex_br_op, bus.ex_rd,
                      bus.ex_rf_we, bus.ex_is_load},
                     {17'd0, m_ex.alu, m_ex.bsel, m_ex.br, m_ex.rd, m_ex.we, m_ex.ld});
      chk("ex_A", bus.ex_A, m_ex.a);
      chk("ex_rD2", bus.ex_rD2, m_ex.d2);
      chk("ex_sext", bus.ex_sext, m_ex.sx);
    end
    @(posedge clk);
    if (rst) m_known = 1'b1;
    m_ex = m_nxt;
    m_stalled = m_stalled_nxt;
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic bsel, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] sx);
    bus.id_valid = v;  bus.id_alu_op = 4'h3; bus.id_b_sel = bsel; bus.id_br_op = 3'd0;
    bus.id_rs1 = rs1;  bus.id_rs2 = rs2; bus.id_rd = rd; bus.id_rf_we = we;
    bus.id_is_load = ld; bus.id_rD1 = r1; bus.id_rD2 = r2; bus.id_sext = sx;
  endtask

  task automatic clr_src();
    bus.ex_f = 1'b0; bus.ex_C = 32'd0;
    bus.mem_we = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
    bus.wb_we = 1'b0;  bus.wb_rd = 5'd0;  bus.wb_data = 32'd0;
  endtask

  task automatic load_then_use();
    set_id(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, B_SEL_EXT, 32'h0, 32'h0, 32'h4);
    cycle();
    set_id(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, B_SEL_RD2, 32'h1111, 32'h2222, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    clr_src();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, B_SEL_RD2, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("rst_stall", {31'd0, obs_stall}, 32'd0);
    cycle();
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ex_A", bus.ex_A, 32'd0);
    rst = 1'b0;

    // EX forward: addi x5 then add x6,x5,x0 with stale rD1.
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, B_SEL_EXT, 32'h0, 32'h0, 32'h10);
    cycle();
    bus.ex_C = 32'h10;
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, B_SEL_RD2, 32'hDEAD, 32'h0, 32'h0);
    cycle();
    chk("fwd_ex_A", bus.ex_A, 32'h10);
    chk("model_fwd_ex_A", m_ex.a, 32'h10);

    // ex beats mem for x7; then x0 reads zero even with mem_rd=0.
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, B_SEL_EXT, 32'h1, 32'h0, 32'h0);
    cycle();
    bus.ex_C = 32'hAA; bus.mem_we = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hBB;
    set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0, B_SEL_EXT, 32'h77, 32'h0, 32'h0);
    cycle();
    chk("prio_ex_A", bus.ex_A, 32'hAA);
    bus.mem_rd = 5'd0; bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hCC;
    set_id(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, B_SEL_EXT, 32'h55, 32'h0, 32'h0);
    cycle();
    chk("x0_ex_A", bus.ex_A, 32'h0);

    // Load-use: one stall, then the held add issues with mem forwarding.
    clr_src();
    load_then_use();
    cycle();
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    bus.mem_we = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'h1234;
    cycle();
    chk("lu_release_stall", {31'd0, obs_stall}, 32'd0);
    chk("lu_ex_A", bus.ex_A, 32'h1234);
    chk("model_lu_ex_A", m_ex.a, 32'h1234);
    chk("lu_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

    // Flush in the hazard cycle wins over the stall.
    clr_src();
    load_then_use();
    bus.ex_f = 1'b1;
    cycle();
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);
    chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    bus.ex_f = 1'b0;
    cycle();
    chk("post_flush_valid", {31'd0, bus.ex_valid}, 32'd1);

    // Reset while in the bubble state.
    load_then_use();
    cycle();
    chk("rb_stall", {31'd0, obs_stall}, 32'd1);
    rst = 1'b1;
    cycle();
    chk("rb_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rb_stall_rst", {31'd0, obs_stall}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("rb_no_extra_stall", {31'd0, obs_stall}, 32'd0);
    chk("rb_reissue", {31'd0, bus.ex_valid}, 32'd1);

    // Random traffic; ID is held while stalled, as the real front end would.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.ex_f = ($urandom_range(9) == 0);
      bus.ex_C = $urandom;
      bus.mem_we = $urandom_range(1); bus.mem_rd = 5'($urandom_range(7));
      bus.mem_data = $urandom;
      bus.wb_we = $urandom_range(1);  bus.wb_rd = 5'($urandom_range(7));
      bus.wb_data = $urandom;
      if (!obs_stall) begin
        bus.id_valid = ($urandom_range(4) != 0);
        bus.id_alu_op = 4'($urandom_range(15));
        bus.id_b_sel = $urandom_range(1);
        bus.id_br_op = 3'($urandom_range(7));
        bus.id_rs1 = 5'($urandom_range(7));
        bus.id_rs2 = 5'($urandom_range(7));
        bus.id_rd = 5'($urandom_range(7));
        bus.id_rf_we = ($urandom_range(3) != 0);
        bus.id_is_load = ($urandom_range(2) == 0);
        bus.id_rD1 = $urandom; bus.id_rD2 = $urandom; bus.id_sext = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
